// File: rtl/lgbs_gate_sequencer.sv
// lgbs_gate_sequencer
// Command-driven gate sequencer for the three-leg bridge. Assembles two-byte
// frames from uart_rx into {sector[2:0], width[12:0]}, arms on a valid frame,
// fires one gate pulse of `width` cycles on a rising edge of `shoot`, then
// holds all gates off for DEAD_TIME cycles before accepting a new command.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   rx_done        one-cycle byte strobe from uart_rx
//   data_received  received byte, valid with rx_done
//   parity_error   rejects the byte strobed by rx_done
//   shoot          asynchronous fire request (synchronized here)
//   gate[5:0]      {g3_b, g3_a, g2_b, g2_a, g1_b, g1_a}, 1 = transistor on
//   armed          valid command loaded, waiting for shoot
//   busy           pulse or dead-time in progress
//   err            sticky error, cleared by a valid frame or reset
module lgbs_gate_sequencer #(
   parameter int unsigned DEAD_TIME  = 48,
   parameter int unsigned RX_TIMEOUT = 48000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx_done,
   input  logic [7:0] data_received,
   input  logic       parity_error,
   input  logic       shoot,
   output logic [5:0] gate,
   output logic       armed,
   output logic       busy,
   output logic       err
);

   localparam int unsigned WIDTH_W = 13;
   localparam int unsigned DEAD_W  = $clog2(DEAD_TIME) + 1;
   localparam int unsigned TO_W    = $clog2(RX_TIMEOUT) + 1;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WAIT_B2 = 3'd1,
      ST_ARMED   = 3'd2,
      ST_PULSE   = 3'd3,
      ST_DEAD    = 3'd4
   } state_t;

   state_t              state;
   state_t              state_nxt;

   logic                shoot_s1;
   logic                shoot_s2;
   logic                shoot_prev;
   logic                shoot_rise;

   logic [7:0]          byte1_q;
   logic [15:0]         cmd_q;
   logic [WIDTH_W-1:0]  width_cnt;
   logic [DEAD_W-1:0]   dead_cnt;
   logic [TO_W-1:0]     to_cnt;
   logic                err_q;

   logic [15:0]         frame;
   logic                frame_valid;
   logic                rx_ok;
   logic                rx_bad;
   logic                timed_out;

   logic                ld_b1;
   logic                ld_cmd;
   logic                ld_width;
   logic                ld_dead;
   logic                set_err;
   logic                clr_err;

   logic [5:0]          gate_d;
   logic                armed_d;
   logic                busy_d;

   // Shoot synchronizer and edge detector
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         shoot_s1   <= 1'b0;
         shoot_s2   <= 1'b0;
         shoot_prev <= 1'b0;
      end else begin
         shoot_s1   <= shoot;
         shoot_s2   <= shoot_s1;
         shoot_prev <= shoot_s2;
      end
   end

   assign shoot_rise  = shoot_s2 & ~shoot_prev;
   assign rx_ok       = rx_done & ~parity_error;
   assign rx_bad      = rx_done & parity_error;
   assign frame       = {byte1_q, data_received};
   assign frame_valid = (frame[15:13] <= 3'd5) && (frame[12:0] != 13'd0);
   assign timed_out   = (to_cnt == TO_W'(RX_TIMEOUT));

   // State register
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ST_IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic and datapath load strobes
   always_comb begin
      state_nxt = state;
      ld_b1     = 1'b0;
      ld_cmd    = 1'b0;
      ld_width  = 1'b0;
      ld_dead   = 1'b0;
      set_err   = 1'b0;
      clr_err   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (rx_ok) begin
               ld_b1     = 1'b1;
               state_nxt = ST_WAIT_B2;
            end else if (rx_bad) begin
               set_err   = 1'b1;
            end
         end
         ST_WAIT_B2: begin
            // Timeout takes priority over a byte arriving in the same cycle
            if (timed_out || rx_bad) begin
               set_err   = 1'b1;
               state_nxt = ST_IDLE;
            end else if (rx_ok) begin
               if (frame_valid) begin
                  ld_cmd    = 1'b1;
                  clr_err   = 1'b1;
                  state_nxt = ST_ARMED;
               end else begin
                  set_err   = 1'b1;
                  state_nxt = ST_IDLE;
               end
            end
         end
         ST_ARMED: begin
            // A coincident byte is dropped in favour of the shot
            if (shoot_rise) begin
               ld_width  = 1'b1;
               state_nxt = ST_PULSE;
            end else if (rx_ok) begin
               ld_b1     = 1'b1;
               state_nxt = ST_WAIT_B2;
            end
         end
         ST_PULSE: begin
            if (width_cnt <= WIDTH_W'(1)) begin
               ld_dead   = 1'b1;
               state_nxt = ST_DEAD;
            end
         end
         ST_DEAD: begin
            if (dead_cnt <= DEAD_W'(1)) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Frame capture, counters and sticky error
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         byte1_q   <= 8'd0;
         cmd_q     <= 16'd0;
         width_cnt <= '0;
         dead_cnt  <= '0;
         to_cnt    <= '0;
         err_q     <= 1'b0;
      end else begin
         if (ld_b1)  byte1_q <= data_received;
         if (ld_cmd) cmd_q   <= frame;

         if (set_err)      err_q <= 1'b1;
         else if (clr_err) err_q <= 1'b0;

         if (ld_b1)
            to_cnt <= '0;
         else if (state == ST_WAIT_B2 && !timed_out)
            to_cnt <= to_cnt + TO_W'(1);

         if (ld_width)
            width_cnt <= cmd_q[12:0];
         else if (state == ST_PULSE && width_cnt != '0)
            width_cnt <= width_cnt - WIDTH_W'(1);

         if (ld_dead)
            dead_cnt <= DEAD_W'(DEAD_TIME);
         else if (state == ST_DEAD && dead_cnt != '0)
            dead_cnt <= dead_cnt - DEAD_W'(1);
      end
   end

   // Output decode; sector table never enables both switches of one leg
   always_comb begin
      gate_d  = 6'b000000;
      armed_d = (state == ST_ARMED);
      busy_d  = (state == ST_PULSE) || (state == ST_DEAD);
      if (state == ST_PULSE) begin
         case (cmd_q[15:13])
            3'd0:    gate_d = 6'b001001;
            3'd1:    gate_d = 6'b100001;
            3'd2:    gate_d = 6'b100100;
            3'd3:    gate_d = 6'b000110;
            3'd4:    gate_d = 6'b010010;
            3'd5:    gate_d = 6'b011000;
            default: gate_d = 6'b000000;
         endcase
      end
   end

   // Output registers; async reset drops the gates immediately
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         gate  <= 6'b000000;
         armed <= 1'b0;
         busy  <= 1'b0;
         err   <= 1'b0;
      end else begin
         gate  <= gate_d;
         armed <= armed_d;
         busy  <= busy_d;
         err   <= err_q;
      end
   end

endmodule

// File: tb/tb_lgbs_gate_sequencer.sv
// Testbench for lgbs_gate_sequencer: frames are built from sector/width
// values, and each shot is measured (latency, pattern, pulse length, dead
// time, busy span) against values derived from the command rules.
module tb_lgbs_gate_sequencer;

   localparam int unsigned DT = 48;
   localparam int unsigned RT = 48000;

   logic       clk = 1'b0;
   logic       reset;
   logic       rx_done;
   logic [7:0] data_received;
   logic       parity_error;
   logic       shoot;
   logic [5:0] gate;
   logic       armed;
   logic       busy;
   logic       err;

   int n_cmp  = 0;
   int n_fail = 0;
   bit leg_check_en = 1'b0;

   lgbs_gate_sequencer #(.DEAD_TIME(DT), .RX_TIMEOUT(RT)) dut (
      .clk           (clk),
      .reset         (reset),
      .rx_done       (rx_done),
      .data_received (data_received),
      .parity_error  (parity_error),
      .shoot         (shoot),
      .gate          (gate),
      .armed         (armed),
      .busy          (busy),
      .err           (err)
   );

   always #5 clk = ~clk;

   // Sector s pairs the high side of leg s/2 with the low side of the next
   // leg in the rotation 1,2,2,0,0,1 -- i.e. ((s+1)/2 + 1) mod 3.
   function automatic logic [5:0] model_pattern(input int s);
      logic [5:0] p;
      int a_leg;
      int b_leg;
      p = 6'b0;
      a_leg = s / 2;
      b_leg = ((s + 1) / 2 + 1) % 3;
      p[2 * a_leg]     = 1'b1;
      p[2 * b_leg + 1] = 1'b1;
      return p;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit perr);
      data_received = b;
      parity_error  = perr;
      rx_done       = 1'b1;
      tick;
      rx_done       = 1'b0;
      parity_error  = 1'b0;
   endtask

   task automatic send_frame(input int s, input int w);
      logic [15:0] cmd;
      cmd = {3'(s), 13'(w)};
      send_byte(cmd[15:8], 1'b0);
      send_byte(cmd[7:0], 1'b0);
   endtask

   // Raises shoot and measures the resulting shot; optionally injects a byte
   // on the cycle the rise is seen and re-pulses shoot during pulse and dead.
   task automatic measure_shot(input int reshoot_at, input bit coincide, input logic [7:0] cbyte,
                               output int lat, output bit armed_before, output bit armed_at_rise,
                               output logic [5:0] pat, output int hi, output int dead,
                               output int busy_cnt, output bit end_busy);
      logic prev_armed;
      lat = 0; hi = 0; dead = 0; busy_cnt = 0; pat = 6'b0;
      armed_before = 1'b0; armed_at_rise = 1'b0; end_busy = 1'b1;
      prev_armed = armed;
      shoot = 1'b1;
      while (lat < 20) begin
         prev_armed = armed;
         tick;
         lat++;
         if (lat == 2) begin
            shoot = 1'b0;
            if (coincide) begin
               data_received = cbyte;
               parity_error  = 1'b0;
               rx_done       = 1'b1;
            end
         end
         if (lat == 3) rx_done = 1'b0;
         if (gate !== 6'b0) break;
      end
      if (gate === 6'b0) begin
         end_busy = busy;
         return;
      end
      armed_before  = prev_armed;
      armed_at_rise = armed;
      pat = gate;
      hi = 1;
      busy_cnt = (busy === 1'b1) ? 1 : 0;
      while (hi < 9000) begin
         tick;
         if (reshoot_at > 0 && hi == reshoot_at)     shoot = 1'b1;
         if (reshoot_at > 0 && hi == reshoot_at + 3) shoot = 1'b0;
         if (gate !== pat) break;
         hi++;
         if (busy === 1'b1) busy_cnt++;
      end
      while (dead < 200 && busy === 1'b1 && gate === 6'b0) begin
         dead++;
         busy_cnt++;
         if (reshoot_at > 0 && dead == 10) shoot = 1'b1;
         if (reshoot_at > 0 && dead == 13) shoot = 1'b0;
         tick;
      end
      end_busy = busy;
      shoot = 1'b0;
   endtask

   // No leg may ever have both switches on
   always @(negedge clk) begin
      if (leg_check_en && reset === 1'b0) begin
         n_cmp++;
         if (((gate[0] & gate[1]) | (gate[2] & gate[3]) | (gate[4] & gate[5])) !== 1'b0) begin
            n_fail++;
            $display("FAIL leg_overlap: gate=%b, required no leg with both switches on", gate);
         end
      end
   end

   task automatic test_reset;
      reset = 1'b1; rx_done = 1'b0; parity_error = 1'b0; data_received = 8'h00; shoot = 1'b0;
      #2;
      n_cmp++; if (gate !== 6'b0) begin n_fail++; $display("FAIL reset_gate: got %b required 000000", gate); end
      n_cmp++; if (armed !== 1'b0) begin n_fail++; $display("FAIL reset_armed: got %b required 0", armed); end
      n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL reset_err: got %b required 0", err); end
      tick; tick;
      reset = 1'b0;
      tick;
      n_cmp++; if ({gate, armed, busy, err} !== 9'b0) begin n_fail++; $display("FAIL reset_release_outputs: got %b required 0", {gate, armed, busy, err}); end
      leg_check_en = 1'b1;
   endtask

   task automatic test_basic;
      int lat, hi, dead, bc; bit ab, ar, eb; logic [5:0] pat;
      send_byte(8'h20, 1'b0);
      send_byte(8'h0A, 1'b0);
      tick;
      n_cmp++; if (armed !== 1'b1) begin n_fail++; $display("FAIL basic_armed: got %b required 1", armed); end
      n_cmp++; if (err !== 1'b0) begin n_fail++; $display("FAIL basic_err: got %b required 0", err); end
      measure_shot(0, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
      n_cmp++; if (lat !== 4) begin n_fail++; $display("FAIL basic_latency: got %0d edges required 4", lat); end
      n_cmp++; if (pat !== 6'b100001) begin n_fail++; $display("FAIL basic_pattern: got %b required 100001", pat); end
      n_cmp++; if (ab !== 1'b1 || ar !== 1'b0) begin n_fail++; $display("FAIL basic_armed_fall: got before=%b at_rise=%b required 1/0", ab, ar); end
      n_cmp++; if (hi !== 10) begin n_fail++; $display("FAIL basic_width: got %0d required 10", hi); end
      n_cmp++; if (dead !== DT) begin n_fail++; $display("FAIL basic_dead: got %0d required %0d", dead, DT); end
      n_cmp++; if (bc !== 10 + DT) begin n_fail++; $display("FAIL basic_busy_span: got %0d required %0d", bc, 10 + DT); end
      n_cmp++; if (eb !== 1'b0 || armed !== 1'b0) begin n_fail++; $display("FAIL basic_idle_after: got busy=%b armed=%b required 0/0", eb, armed); end
   endtask

   task automatic test_sector_sweep;
      int lat, hi, dead, bc; bit ab, ar, eb; logic [5:0] pat;
      for (int s = 0; s < 6; s++) begin
         send_frame(s, 1);
         tick;
         measure_shot(0, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
         n_cmp++; if (pat !== model_pattern(s)) begin n_fail++; $display("FAIL sweep_pattern s=%0d: got %b required %b", s, pat, model_pattern(s)); end
         n_cmp++; if (hi !== 1 || lat !== 4 || dead !== DT) begin n_fail++; $display("FAIL sweep_timing s=%0d: got width=%0d lat=%0d dead=%0d required 1/4/%0d", s, hi, lat, dead, DT); end
      end
   endtask

   task automatic test_random_shots;
      int lat, hi, dead, bc; bit ab, ar, eb; logic [5:0] pat;
      int s, w, d;
      for (int i = 0; i < 12; i++) begin
         s = int'($urandom_range(0, 5));
         w = int'($urandom_range(1, 40));
         d = int'($urandom_range(0, 6));
         send_frame(s, w);
         repeat (d + 1) tick;
         measure_shot(0, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
         n_cmp++; if (pat !== model_pattern(s)) begin n_fail++; $display("FAIL rand_pattern i=%0d s=%0d: got %b required %b", i, s, pat, model_pattern(s)); end
         n_cmp++; if (hi !== w) begin n_fail++; $display("FAIL rand_width i=%0d: got %0d required %0d", i, hi, w); end
         n_cmp++; if (bc !== w + DT || eb !== 1'b0) begin n_fail++; $display("FAIL rand_busy i=%0d: got span=%0d end=%b required %0d/0", i, bc, eb, w + DT); end
         n_cmp++; if (lat !== 4 || ab !== 1'b1 || ar !== 1'b0) begin n_fail++; $display("FAIL rand_latency i=%0d: got lat=%0d armed=%b->%b required 4 1->0", i, lat, ab, ar); end
      end
   endtask

   task automatic test_errors;
      int lat, hi, dead, bc; bit ab, ar, eb; logic [5:0] pat;
      logic [15:0] cmd;
      send_byte(8'h20, 1'b1);
      tick;
      n_cmp++; if (err !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("FAIL err_parity_b1: got err=%b armed=%b required 1/0", err, armed); end
      measure_shot(0, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
      n_cmp++; if (pat !== 6'b0 || eb !== 1'b0) begin n_fail++; $display("FAIL err_parity_noshot: got gate=%b busy=%b required 000000/0", pat, eb); end
      send_frame(3, 5);
      tick;
      n_cmp++; if (err !== 1'b0 || armed !== 1'b1) begin n_fail++; $display("FAIL err_clear1: got err=%b armed=%b required 0/1", err, armed); end
      send_frame(7, 5);
      tick;
      n_cmp++; if (err !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("FAIL err_sector7: got err=%b armed=%b required 1/0", err, armed); end
      measure_shot(0, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
      n_cmp++; if (pat !== 6'b0 || eb !== 1'b0) begin n_fail++; $display("FAIL err_sector7_noshot: got gate=%b busy=%b required 000000/0", pat, eb); end
      send_frame(0, 9);
      tick;
      n_cmp++; if (err !== 1'b0 || armed !== 1'b1) begin n_fail++; $display("FAIL err_clear2: got err=%b armed=%b required 0/1", err, armed); end
      send_frame(2, 0);
      tick;
      n_cmp++; if (err !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("FAIL err_width0: got err=%b armed=%b required 1/0", err, armed); end
      measure_shot(0, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
      n_cmp++; if (pat !== 6'b0 || eb !== 1'b0) begin n_fail++; $display("FAIL err_width0_noshot: got gate=%b busy=%b required 000000/0", pat, eb); end
      send_frame(6, 4);
      tick;
      n_cmp++; if (err !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("FAIL err_sector6: got err=%b armed=%b required 1/0", err, armed); end
      send_frame(5, 3);
      tick;
      n_cmp++; if (err !== 1'b0 || armed !== 1'b1) begin n_fail++; $display("FAIL err_clear3: got err=%b armed=%b required 0/1", err, armed); end
      cmd = {3'd1, 13'd6};
      send_byte(cmd[15:8], 1'b0);
      send_byte(cmd[7:0], 1'b1);
      tick;
      n_cmp++; if (err !== 1'b1 || armed !== 1'b0) begin n_fail++; $display("FAIL err_parity_b2: got err=%b armed=%b required 1/0", err, armed); end
      send_frame(4, 6);
      tick;
      measure_shot(0, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
      n_cmp++; if (pat !== model_pattern(4) || hi !== 6 || err !== 1'b0) begin n_fail++; $display("FAIL err_recover_shot: got gate=%b width=%0d err=%b required %b/6/0", pat, hi, err, model_pattern(4)); end
   endtask

   task automatic test_back_to_back;
      int lat, hi, dead, bc, act; bit ab, ar, eb; logic [5:0] pat;
      send_frame(4, 12);
      tick;
      measure_shot(0, 1'b1, 8'h21, lat, ab, ar, pat, hi, dead, bc, eb);
      n_cmp++; if (pat !== model_pattern(4) || hi !== 12) begin n_fail++; $display("FAIL coincide_shot: got gate=%b width=%0d required %b/12", pat, hi, model_pattern(4)); end
      n_cmp++; if (armed !== 1'b0 || err !== 1'b0) begin n_fail++; $display("FAIL coincide_byte_dropped: got armed=%b err=%b required 0/0", armed, err); end
      send_frame(5, 20);
      tick;
      measure_shot(5, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
      n_cmp++; if (pat !== model_pattern(5) || hi !== 20 || dead !== DT) begin n_fail++; $display("FAIL reshoot_first: got gate=%b width=%0d dead=%0d required %b/20/%0d", pat, hi, dead, model_pattern(5), DT); end
      act = 0;
      for (int i = 0; i < 30; i++) begin
         tick;
         if (gate !== 6'b0 || armed !== 1'b0 || busy !== 1'b0) act++;
      end
      n_cmp++; if (act !== 0) begin n_fail++; $display("FAIL reshoot_no_second: got %0d active cycles required 0", act); end
   endtask

   task automatic test_timeout;
      int lat, hi, dead, bc; bit ab, ar, eb; logic [5:0] pat;
      send_byte(8'h40, 1'b0);
      repeat (RT + 1) tick;
      n_cmp++; if (err !== 1'b0 || armed !== 1'b0) begin n_fail++; $display("FAIL timeout_early: got err=%b armed=%b required 0/0", err, armed); end
      tick;
      n_cmp++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_err: got %b required 1", err); end
      send_frame(0, 7);
      tick;
      n_cmp++; if (armed !== 1'b1 || err !== 1'b0) begin n_fail++; $display("FAIL timeout_fresh_frame: got armed=%b err=%b required 1/0", armed, err); end
      measure_shot(0, 1'b0, 8'h00, lat, ab, ar, pat, hi, dead, bc, eb);
      n_cmp++; if (pat !== model_pattern(0) || hi !== 7) begin n_fail++; $display("FAIL timeout_fresh_shot: got gate=%b width=%0d required %b/7", pat, hi, model_pattern(0)); end
   endtask

   task automatic test_reset_mid_pulse;
      int act;
      send_frame(2, 8000);
      tick;
      shoot = 1'b1;
      tick; tick;
      shoot = 1'b0;
      repeat (50) tick;
      n_cmp++; if (gate !== model_pattern(2) || busy !== 1'b1) begin n_fail++; $display("FAIL midpulse_active: got gate=%b busy=%b required %b/1", gate, busy, model_pattern(2)); end
      #2;
      reset = 1'b1;
      #1;
      n_cmp++; if (gate !== 6'b0) begin n_fail++; $display("FAIL midpulse_reset_gate: got %b required 000000", gate); end
      n_cmp++; if (busy !== 1'b0 || armed !== 1'b0) begin n_fail++; $display("FAIL midpulse_reset_flags: got busy=%b armed=%b required 0/0", busy, armed); end
      shoot = 1'b1;
      tick; tick;
      reset = 1'b0;
      act = 0;
      for (int i = 0; i < 40; i++) begin
         tick;
         if (i == 10) shoot = 1'b0;
         if (i == 15) shoot = 1'b1;
         if (i == 20) shoot = 1'b0;
         if (gate !== 6'b0 || armed !== 1'b0 || busy !== 1'b0) act++;
      end
      n_cmp++; if (act !== 0) begin n_fail++; $display("FAIL after_reset_shoot_ignored: got %0d active cycles required 0", act); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_sector_sweep();
      test_random_shots();
      test_errors();
      test_back_to_back();
      test_timeout();
      test_reset_mid_pulse();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #3_000_000;
      $display("FAIL watchdog: run exceeded its time budget");
      $fatal(1);
   end

endmodule

// File: doc/lgbs_gate_sequencer.md
# lgbs_gate_sequencer

Command-driven gate sequencer for the three-leg transistor bridge on the FPGA module. It consumes the byte stream from the existing `uart_rx` instance (two-byte frames, parity-checked) and decodes a 16-bit command into a conduction sector and a pulse width. On a rising edge of the external `shoot` input it fires exactly one gate pulse, then enforces a dead-time before accepting the next command. It sits between `uart_rx` and the `gpio_*` gate pins, replacing ad-hoc gate registers in the top level.

## Interface
- `DEAD_TIME`, 48: all-gates-off cycles after every pulse (1 µs at 48 MHz).
- `RX_TIMEOUT`, 48000: maximum cycles between byte 1 and byte 2 of a frame (1 ms).
- `clk` in 1: system clock (48 MHz HFOSC).
- `reset` in 1: reset, asynchronous, active-high.
- `rx_done` in 1: one-cycle strobe from `uart_rx`; `data_received` is valid in that cycle.
- `data_received` in 8: received byte.
- `parity_error` in 1: qualifies `rx_done`; byte rejected when high.
- `shoot` in 1: asynchronous fire request; synchronized internally.
- `gate` out 6: `[0]`=g1_a, `[1]`=g1_b, `[2]`=g2_a, `[3]`=g2_b, `[4]`=g3_a, `[5]`=g3_b; 1 = transistor on.
- `armed` out 1: a valid command is loaded and waiting for `shoot`.
- `busy` out 1: pulse or dead-time in progress.
- `err` out 1: sticky error flag; cleared by the next valid frame or by reset.

## Operation
- Frame: byte 1 → `cmd[15:8]`, byte 2 → `cmd[7:0]`. `cmd[15:13]` = sector; `cmd[12:0]` = width W in clk cycles.
- Sector → gates: 0: g1_a+g2_b; 1: g1_a+g3_b; 2: g2_a+g3_b; 3: g2_a+g1_b; 4: g3_a+g1_b; 5: g3_a+g2_b.
- The mapping never turns on both switches of one leg. A frame with sector 6 or 7, or with W = 0, is invalid.
- States:
  - `IDLE`:
    - Valid `rx_done` → latch byte 1, clear the timeout counter → `WAIT_B2`.
    - `rx_done` with parity error → `err`=1, stay in `IDLE`.
  - `WAIT_B2`:
    - Valid `rx_done` → latch byte 2. A valid frame → `ARMED` and `err`=0; an invalid frame → `IDLE` and `err`=1.
    - Parity error → `IDLE`, `err`=1.
    - Timeout counter reaches `RX_TIMEOUT` → `IDLE`, `err`=1, byte 1 discarded.
  - `ARMED`:
    - `shoot` rising edge → `PULSE`, load the width counter with W.
    - Valid `rx_done` → the loaded command is discarded; treat the byte as byte 1 → `WAIT_B2`.
  - `PULSE`: `gate` = sector pattern; the counter decrements; after W cycles → `DEAD`.
  - `DEAD`: `gate`=0 for `DEAD_TIME` cycles → `IDLE`. The command is consumed: one shot per frame.
- `rx_done` during `PULSE` or `DEAD` is ignored. `shoot` edges outside `ARMED` are ignored and not queued.
- `shoot` goes through a 2-flop synchronizer plus a previous-value flop. Rise = sync2 & ~prev.
- If `rx_done` and a `shoot` rise coincide in `ARMED`, the `shoot` rise wins and the byte is dropped.
- Counters: width counter 13 bit; dead-time and timeout counters use $clog2 of the parameter + 1 bit. No wrap-around is permitted; all counters saturate or reload on state entry.

## Timing
- Reset (async): state `IDLE`; `gate`=6'b0, `armed`=0, `busy`=0, `err`=0; synchronizer flops cleared. `gate` drops within the reset assertion, not at the next edge, including mid-pulse.
- All outputs are registered; no combinational path from inputs to `gate`.
- `shoot` latency: if `shoot` is first sampled high at edge k, `gate` goes high after edge k+3 and stays high for exactly W cycles.
- `gate` is low for exactly `DEAD_TIME` cycles afterwards. `armed` falls at the same edge `gate` rises.
- `busy`=1 from the first `PULSE` cycle through the last `DEAD` cycle.
- `armed` rises in the cycle after the byte-2 `rx_done`. `err` updates in that same cycle.
- The timeout counts cycles in `WAIT_B2`. Byte 2 arriving at count `RX_TIMEOUT`-1 is accepted.
- Minimum shot-to-shot period: W + `DEAD_TIME` + frame time.

## Test plan
- Reset, send bytes 0x20, 0x0A (sector 1, W=10), pulse `shoot` → `armed`=1, then `gate`=6'b100001 for exactly 10 cycles starting 3 edges after `shoot` sampled high, then 0 for 48 cycles; `busy` covers 58 cycles; back to `IDLE`.
- Sweep sectors 0–5 with W=1 → correct single-cycle pattern each time. Check on every cycle that `gate[2n]` & `gate[2n+1]` is never 1.
- Byte 1 with parity error; sector 7 frame; W=0 frame → `err`=1, no `armed`, `shoot` produces no gate activity. A following valid frame clears `err`.
- Send byte 1 only and wait 48000 cycles → `IDLE`, `err`=1. The next two bytes form a fresh frame.
- `ARMED` with `rx_done` and `shoot` rise on the same cycle → pulse fires with the old command and the byte is ignored. Second `shoot` during `PULSE`/`DEAD` → no second pulse.
- Assert `reset` mid-`PULSE` (W=8000) → `gate`=0 immediately. After release: `IDLE`, `armed`=0, and `shoot` is ignored.
